// File: rtl/seq_scan_ctrl_if.sv
// seq_scan_ctrl_if
//   Groups the scan request, configuration, serial input and result
//   signals of seq_scan_ctrl into one bundle.
//
//   master : drives start, cfg_*, in, in_valid; observes the results
//   slave  : the controller; consumes requests and drives busy, done,
//            match_pulse and match_count
//
//   Signals
//     start        request a scan (sampled only while idle)
//     cfg_pattern  target pattern, bit [len-1] is the oldest bit in time
//     cfg_len      pattern length, 0 behaves as 1, above 8 behaves as 8
//     cfg_window   number of valid serial bits to scan
//     cfg_overlap  1 = overlapping matches count, 0 = non-overlapping
//     in           serial data bit
//     in_valid     qualifies in
//     busy         scan in progress (LOAD or SCAN)
//     done         one-cycle completion pulse
//     match_pulse  one-cycle pulse per counted match
//     match_count  matches counted, saturating at 255
interface seq_scan_ctrl_if;
  logic       start;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_window;
  logic       cfg_overlap;
  logic       in;
  logic       in_valid;
  logic       busy;
  logic       done;
  logic       match_pulse;
  logic [7:0] match_count;

  modport master (
    output start,
    output cfg_pattern,
    output cfg_len,
    output cfg_window,
    output cfg_overlap,
    output in,
    output in_valid,
    input  busy,
    input  done,
    input  match_pulse,
    input  match_count
  );

  modport slave (
    input  start,
    input  cfg_pattern,
    input  cfg_len,
    input  cfg_window,
    input  cfg_overlap,
    input  in,
    input  in_valid,
    output busy,
    output done,
    output match_pulse,
    output match_count
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
//   Scans a window of valid serial bits for a configurable pattern of
//   1..8 bits and counts the matches, optionally allowing overlap.
//
//   Ports
//     clk    : single clock, rising edge
//     reset  : asynchronous, active-high; returns to IDLE and clears all
//     bus    : seq_scan_ctrl_if.slave (request, config, serial in, results)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; match_count holds the last result
//   LOAD  | one cycle: latch config, clear history/fill/match_count
//   SCAN  | consume valid bits until the window is exhausted
//   DONE  | one cycle: done=1, then back to IDLE
module seq_scan_ctrl (
  input  logic           clk,
  input  logic           reset,
  seq_scan_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0] state;

  // latched configuration, frozen for the whole scan
  logic [7:0] pat_q;
  logic [3:0] len_q;
  logic       ovl_q;

  // scan progress
  logic [7:0] rem_q;    // valid bits still to consume
  logic [7:0] hist_q;   // newest bit in bit 0
  logic [3:0] fill_q;   // bits in history that may take part in a match
  logic [7:0] cnt_q;
  logic       pulse_q;

  logic [3:0] len_clamped;
  logic [7:0] hist_nxt;
  logic [3:0] fill_nxt;
  logic [7:0] len_mask;
  logic       hit;

  always_comb begin
    len_clamped = bus.cfg_len;
    if (bus.cfg_len == 4'd0) begin
      len_clamped = 4'd1;
    end else if (bus.cfg_len > 4'd8) begin
      len_clamped = 4'd8;
    end
  end

  // Match evaluation looks at the history as it will be after the
  // current bit is shifted in, so the bit itself takes part.
  always_comb begin
    hist_nxt = {hist_q[6:0], bus.in};
    fill_nxt = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
    len_mask = 8'hFF >> (4'd8 - len_q);
    hit      = (((hist_nxt ^ pat_q) & len_mask) == 8'h00) && (fill_nxt >= len_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      pat_q   <= 8'h00;
      len_q   <= 4'd0;
      ovl_q   <= 1'b0;
      rem_q   <= 8'h00;
      hist_q  <= 8'h00;
      fill_q  <= 4'd0;
      cnt_q   <= 8'h00;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          pat_q  <= bus.cfg_pattern;
          len_q  <= len_clamped;
          rem_q  <= bus.cfg_window;
          ovl_q  <= bus.cfg_overlap;
          hist_q <= 8'h00;
          fill_q <= 4'd0;
          cnt_q  <= 8'h00;
          state  <= (bus.cfg_window == 8'h00) ? ST_DONE : ST_SCAN;
        end

        ST_SCAN: begin
          if (bus.in_valid) begin
            hist_q <= hist_nxt;
            rem_q  <= rem_q - 8'd1;
            if (hit) begin
              pulse_q <= 1'b1;
              if (cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
              end
              // non-overlapping: the matched bits may not be reused
              fill_q <= ovl_q ? fill_nxt : 4'd0;
            end else begin
              fill_q <= fill_nxt;
            end
            if (rem_q == 8'd1) begin
              state <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = (state == ST_LOAD) || (state == ST_SCAN);
  assign bus.done        = (state == ST_DONE);
  assign bus.match_pulse = pulse_q;
  assign bus.match_count = cnt_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
module tb_seq_scan_ctrl;

  logic clk = 1'b0;
  logic reset;

  seq_scan_ctrl_if sif ();

  seq_scan_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int kind;   // 0 = match pulse, 1 = done
    int cnt;    // match_count expected while the event is visible
    int cyc;    // cycle number in which the event must be visible
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  bit  sbits [0:255];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic mon_check(input int kind);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: nothing pending at cycle %0d, count=%0d",
               (kind == 1) ? "done" : "match", cyc, sif.match_count);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cnt != int'(sif.match_count) || e.cyc != cyc) begin
        bad++;
        $display("FAIL event: got kind=%0d count=%0d cycle=%0d, required kind=%0d count=%0d cycle=%0d",
                 kind, sif.match_count, cyc, e.kind, e.cnt, e.cyc);
      end
    end
  endtask

  // monitor: observe outputs between clock edges
  always @(negedge clk) begin
    if (!reset) begin
      if (sif.match_pulse) mon_check(0);
      if (sif.done) mon_check(1);
    end
  end

  task automatic scramble_cfg();
    sif.cfg_pattern = 8'($urandom);
    sif.cfg_len     = 4'($urandom);
    sif.cfg_window  = 8'($urandom);
    sif.cfg_overlap = 1'($urandom);
  endtask

  task automatic load_vec9(input logic [8:0] v);
    for (int i = 0; i < 9; i++) sbits[i] = v[8 - i];
  endtask

  // Drives one scan and predicts its events from the pattern rules:
  // remember the bits received since the last reset of the match window,
  // and a match is the last L of them reading the pattern oldest-first.
  task automatic run_scan(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] win,
                          input logic ovl, input int gap_mode, input int abort_after);
    int  L;
    int  cnt;
    bit  hq[$];
    bit  hit;
    ev_t e;
    L   = (len == 4'd0) ? 1 : ((len > 4'd8) ? 8 : int'(len));
    cnt = 0;

    @(negedge clk);
    sif.cfg_pattern = pat;
    sif.cfg_len     = len;
    sif.cfg_window  = win;
    sif.cfg_overlap = ovl;
    sif.start       = 1'b1;
    sif.in_valid    = 1'b1;
    sif.in          = 1'($urandom);

    @(negedge clk);
    sif.start = 1'b0;
    chk("busy_in_load", int'(sif.busy), 1);

    if (win == 8'd0) begin
      e.kind = 1; e.cnt = 0; e.cyc = cyc + 1;
      exp_q.push_back(e);
      @(negedge clk);
    end else begin
      for (int i = 0; i < int'(win); i++) begin
        if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
          @(negedge clk);
          scramble_cfg();
          sif.in_valid = 1'b0;
          sif.in       = 1'($urandom);
          sif.start    = 1'($urandom);
        end
        @(negedge clk);
        if (i == abort_after) begin
          sif.in_valid = 1'b0;
          sif.start    = 1'b0;
          #2 reset = 1'b1;
          #1;
          chk("abort_busy", int'(sif.busy), 0);
          chk("abort_done", int'(sif.done), 0);
          chk("abort_count", int'(sif.match_count), 0);
          @(negedge clk);
          reset = 1'b0;
          return;
        end
        scramble_cfg();
        sif.start    = 1'($urandom);
        sif.in       = sbits[i];
        sif.in_valid = 1'b1;

        hq.push_back(sbits[i]);
        if (hq.size() > 8) void'(hq.pop_front());
        hit = 1'b0;
        if (hq.size() >= L) begin
          hit = 1'b1;
          for (int k = 0; k < L; k++) begin
            if (hq[hq.size() - 1 - k] != pat[k]) hit = 1'b0;
          end
        end
        if (hit) begin
          if (cnt < 255) cnt++;
          e.kind = 0; e.cnt = cnt; e.cyc = cyc + 1;
          exp_q.push_back(e);
          if (!ovl) hq.delete();
        end
        if (i == int'(win) - 1) begin
          e.kind = 1; e.cnt = cnt; e.cyc = cyc + 1;
          exp_q.push_back(e);
        end
      end
      @(negedge clk);
      sif.in_valid = 1'b0;
      sif.start    = 1'b0;
    end
    @(negedge clk);
    chk("busy_after_done", int'(sif.busy), 0);
    chk("done_after_done", int'(sif.done), 0);
  endtask

  initial begin
    logic [7:0] rpat;
    logic [3:0] rlen;
    logic [7:0] rwin;

    reset           = 1'b1;
    sif.start       = 1'b0;
    sif.cfg_pattern = 8'h00;
    sif.cfg_len     = 4'd0;
    sif.cfg_window  = 8'h00;
    sif.cfg_overlap = 1'b0;
    sif.in          = 1'b0;
    sif.in_valid    = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_busy", int'(sif.busy), 0);
    chk("reset_done", int'(sif.done), 0);
    chk("reset_match_pulse", int'(sif.match_pulse), 0);
    chk("reset_match_count", int'(sif.match_count), 0);
    reset = 1'b0;

    // overlapping, non-overlapping and gapped versions of the same stream
    load_vec9(9'b111010100);
    run_scan(8'h0A, 4'd4, 8'd9, 1'b1, 0, -1);
    chk("overlap_count", int'(sif.match_count), 2);
    run_scan(8'h0A, 4'd4, 8'd9, 1'b0, 0, -1);
    chk("nonoverlap_count", int'(sif.match_count), 1);
    run_scan(8'h0A, 4'd4, 8'd9, 1'b1, 1, -1);
    chk("gapped_count", int'(sif.match_count), 2);

    // empty window
    run_scan(8'h5A, 4'd3, 8'd0, 1'b1, 0, -1);
    chk("zero_window_count", int'(sif.match_count), 0);

    // saturation at 255 matches
    for (int i = 0; i < 256; i++) sbits[i] = 1'b1;
    run_scan(8'h01, 4'd1, 8'd255, 1'b1, 0, -1);
    chk("saturated_count", int'(sif.match_count), 255);
    repeat (4) @(negedge clk);
    chk("count_held_idle", int'(sif.match_count), 255);

    // a length above 8 behaves as 8
    rpat = 8'hB4;
    for (int i = 0; i < 40; i++) sbits[i] = rpat[7 - (i % 8)];
    run_scan(rpat, 4'd12, 8'd40, 1'b1, 0, -1);
    chk("len12_count", int'(sif.match_count), 5);
    run_scan(rpat, 4'd12, 8'd40, 1'b0, 2, -1);
    chk("len12_nonoverlap_count", int'(sif.match_count), 5);

    // reset after three bits, then a fresh scan
    load_vec9(9'b111010100);
    run_scan(8'h0A, 4'd4, 8'd9, 1'b1, 0, 3);
    chk("after_abort_count", int'(sif.match_count), 0);
    run_scan(8'h0A, 4'd4, 8'd9, 1'b1, 2, -1);
    chk("fresh_scan_count", int'(sif.match_count), 2);

    // randomized scans
    for (int n = 0; n < 40; n++) begin
      rpat = 8'($urandom);
      rlen = 4'($urandom);
      rwin = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 48));
      for (int i = 0; i < 256; i++) sbits[i] = 1'($urandom);
      run_scan(rpat, rlen, rwin, 1'($urandom), 2, -1);
    end

    repeat (3) @(negedge clk);
    chk("pending_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port: start  input  1  request a scan; sampled only in IDLE.
REQ-004 SHALL have port: cfg_pattern  input  8  target pattern; bit [len-1] is the first bit received in time.
REQ-005 SHALL have port: cfg_len  input  4  pattern length; 0 is treated as 1, values above 8 as 8.
REQ-006 SHALL have port: cfg_window  input  8  number of valid serial bits to scan.
REQ-007 SHALL have port: cfg_overlap  input  1  1 = overlapping matches count, 0 = non-overlapping.
REQ-008 SHALL have port: in  input  1  serial data bit.
REQ-009 SHALL have port: in_valid  input  1  in is consumed in cycles where in_valid=1.
REQ-010 SHALL have port: busy  output  1  high in the LOAD and SCAN states.
REQ-011 SHALL have port: done  output  1  one-cycle pulse when a scan completes.
REQ-012 SHALL have port: match_pulse  output  1  one-cycle pulse per counted match.
REQ-013 SHALL have port: match_count  output  8  matches counted in the current or last scan; saturates at 255.

Function
REQ-014 SHALL implement the states IDLE, LOAD, SCAN and DONE.
REQ-015 In IDLE, start=1 SHALL move the state to LOAD on the next edge; start outside IDLE SHALL be ignored.
REQ-016 LOAD SHALL last one cycle and SHALL do all of the following:
- latch cfg_pattern, the clamped cfg_len, cfg_window and cfg_overlap;
- clear the history shift register, fill counter and match_count;
- go to DONE if cfg_window=0, otherwise go to SCAN.
REQ-017 Config inputs SHALL NOT affect a scan after LOAD.
REQ-018 In SCAN, each in_valid=1 cycle SHALL update state as follows:
- shift in into history bit 0;
- increment the fill counter, saturating at 8;
- decrement the remaining-bit counter.
REQ-019 A match SHALL be flagged on a valid bit when both conditions hold:
- history[len-1:0], including the new bit, equals cfg_pattern[len-1:0];
- the fill counter, including the new bit, is at least len.
REQ-020 On a match, match_pulse SHALL be 1 in the following cycle, and match_count SHALL increment by one at the same edge, saturating at 255.
REQ-021 When cfg_overlap=0, the fill counter SHALL reset to 0 after a match; when cfg_overlap=1, it SHALL be unaffected.
REQ-022 in_valid=0 cycles in SCAN SHALL leave history, the counters and the state unchanged.
REQ-023 On the valid bit that brings the remaining count to 0, the state SHALL move to DONE, and a match on that bit SHALL still be counted.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-025 match_count SHALL hold its value from DONE until the next LOAD.
REQ-026 busy SHALL be 0 in IDLE and DONE.
REQ-027 in and in_valid SHALL be ignored outside SCAN.

Reset
REQ-028 While reset=1, the block SHALL hold: state=IDLE, busy=0, done=0, match_pulse=0, match_count=0, and all internal registers cleared.
REQ-029 Reset asserted mid-scan SHALL abort the scan with no done pulse.
REQ-030 After reset deasserts, the next start SHALL begin a fresh scan.

Verification
REQ-031 Overlap scan: pattern=0x0A, len=4, window=9, overlap=1, bits 1,1,1,0,1,0,1,0,0, all valid -> match_pulse after bit indices 5 and 7 -> done with match_count=2.
REQ-032 Non-overlap scan: same stimulus as REQ-031 with overlap=0 -> single match after bit 5 -> match_count=1.
REQ-033 Gapped scan: same stimulus as REQ-031 with in_valid=0 inserted between every pair of bits -> identical match_count; done arrives later.
REQ-034 Zero window: window=0 with start -> sequence IDLE, LOAD, DONE -> done pulse with match_count=0.
REQ-035 Saturation and clamping, covering both:
- len=1, pattern=0x01, window=255, 255 ones -> match_count=255 with no wrap;
- len=12 -> behaves exactly as len=8.
REQ-036 Reset and ignored start, covering both:
- reset asserted after 3 bits of a scan -> busy drops immediately, no done pulse, match_count=0;
- start pulsed during SCAN -> no effect on the scan.
